// File: rtl/stream_tx_arbiter.sv
// stream_tx_arbiter
//   Round-robin burst arbiter sharing one host-bound byte stream between NCH
//   upstream stream sources. One source is granted per burst (at most
//   MAX_BURST data words), optionally preceded by a channel-header word
//   {4'hA, channel}. Sources flagging ihalffull win arbitration ahead of the
//   others; urgency is only looked at between bursts.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   itvalid    per-source valid            [NCH]
//   itready    per-source ready (<= 1 hot) [NCH]
//   itdata     source i at [i*DSIZE*8 +: DSIZE*8]
//   ihalffull  per-source urgency hint     [NCH]
//   otvalid    output valid
//   otready    output ready from downstream
//   otdata     output word                 [DSIZE*8]
//   otlast     data beat that completes a MAX_BURST burst
//   och        granted source index (0 while idle)
module stream_tx_arbiter #(
  parameter int NCH       = 4,
  parameter int DSIZE     = 1,
  parameter int MAX_BURST = 64,
  parameter int HEADER_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         itvalid,
  output logic [NCH-1:0]         itready,
  input  logic [NCH*DSIZE*8-1:0] itdata,
  input  logic [NCH-1:0]         ihalffull,
  output logic                   otvalid,
  input  logic                   otready,
  output logic [DSIZE*8-1:0]     otdata,
  output logic                   otlast,
  output logic [3:0]             och
);

  localparam int DW = DSIZE * 8;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      grant, grant_nx;
  logic [3:0]      last_grant, last_grant_nx;
  logic [BW-1:0]   beat_cnt, beat_cnt_nx;

  logic [NCH-1:0]  urgent;
  logic [NCH-1:0]  cand;
  logic [NCH-1:0]  rot;
  logic [4:0]      base;
  logic [4:0]      pos;
  logic            found;
  logic [3:0]      pick;
  logic            sel_valid;
  logic [DW-1:0]   sel_data;

  // Selected source's valid/data, muxed by grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant == 4'(i)) begin
        sel_valid = itvalid[i];
        sel_data  = itdata[i*DW +: DW];
      end
    end
  end

  // Round-robin pick: rotate the candidate set so bit 0 corresponds to
  // last_grant+1, take the lowest set bit, then map back to a source index.
  always_comb begin
    urgent = itvalid & ihalffull;
    cand   = (|urgent) ? urgent : itvalid;
    base   = 5'(last_grant) + 5'd1;
    if (base >= 5'(NCH)) begin
      base = '0;
    end
    rot   = NCH'({cand, cand} >> base);
    found = 1'b0;
    pick  = last_grant;
    pos   = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = base + 5'(j);
        if (pos >= 5'(NCH)) begin
          pos = pos - 5'(NCH);
        end
        pick = 4'(pos);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= 4'(NCH - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      beat_cnt   <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    beat_cnt_nx   = beat_cnt;
    otvalid       = 1'b0;
    otdata        = '0;
    otlast        = 1'b0;
    och           = '0;
    itready       = '0;

    case (state)
      S_IDLE: begin
        if (|itvalid) begin
          grant_nx      = pick;
          last_grant_nx = pick;
          beat_cnt_nx   = '0;
          state_nx      = (HEADER_EN != 0) ? S_HDR : S_DATA;
        end
      end

      S_HDR: begin
        otvalid     = 1'b1;
        otdata[7:0] = {4'hA, grant};
        och         = grant;
        if (otready) begin
          state_nx = S_DATA;
        end
      end

      S_DATA: begin
        otvalid = sel_valid;
        otdata  = sel_data;
        och     = grant;
        otlast  = sel_valid && (beat_cnt == LAST_CNT);
        for (int unsigned i = 0; i < NCH; i++) begin
          itready[i] = (grant == 4'(i)) && otready;
        end
        // A gap on the granted source ends the burst early; framing
        // downstream is carried by the header, not by otlast.
        if (!sel_valid) begin
          state_nx = S_IDLE;
        end else if (otready) begin
          beat_cnt_nx = beat_cnt + BW'(1);
          if (otlast) begin
            state_nx = S_IDLE;
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_tx_arbiter.sv
module tb_stream_tx_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  a_itvalid, a_itready, a_ihalffull, a_och;
  logic [31:0] a_itdata;
  logic        a_otvalid, a_otready, a_otlast;
  logic [7:0]  a_otdata;

  logic [3:0]  b_itvalid, b_itready, b_ihalffull, b_och;
  logic [31:0] b_itdata;
  logic        b_otvalid, b_otready, b_otlast;
  logic [7:0]  b_otdata;

  int n_pass;
  int n_total;

  stream_tx_arbiter #(.NCH(4), .DSIZE(1), .MAX_BURST(4), .HEADER_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .itvalid(a_itvalid), .itready(a_itready), .itdata(a_itdata),
    .ihalffull(a_ihalffull),
    .otvalid(a_otvalid), .otready(a_otready), .otdata(a_otdata),
    .otlast(a_otlast), .och(a_och)
  );

  stream_tx_arbiter #(.NCH(4), .DSIZE(1), .MAX_BURST(2), .HEADER_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .itvalid(b_itvalid), .itready(b_itready), .itdata(b_itdata),
    .ihalffull(b_ihalffull),
    .otvalid(b_otvalid), .otready(b_otready), .otdata(b_otdata),
    .otlast(b_otlast), .och(b_och)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] v;
    logic [3:0] hf;
    logic       rdy;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [3:0] ech;
    logic [3:0] erdy;
  } vec_t;

  vec_t tbl[$];

  // Every lane carries d with a lane-specific XOR so a wrong select is
  // visible; source 2 carries d unchanged.
  function automatic logic [31:0] lanes(input logic [7:0] d);
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++) begin
      r[i*8 +: 8] = d ^ (8'(i ^ 32'd2) << 6);
    end
    return r;
  endfunction

  function automatic void add(input logic [3:0] v, input logic [3:0] hf,
                              input logic rdy, input logic [7:0] d,
                              input logic ev, input logic [7:0] ed,
                              input logic el, input logic [3:0] ech,
                              input logic [3:0] erdy);
    vec_t t;
    t.v = v; t.hf = hf; t.rdy = rdy; t.d = d;
    t.ev = ev; t.ed = ed; t.el = el; t.ech = ech; t.erdy = erdy;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_table(input string tag);
    for (int n = 0; n < tbl.size(); n++) begin
      @(posedge clk);
      #1;
      a_itvalid   = tbl[n].v;
      a_ihalffull = tbl[n].hf;
      a_otready   = tbl[n].rdy;
      a_itdata    = lanes(tbl[n].d);
      @(negedge clk);
      chk({tag, "_otvalid"}, n, 32'(a_otvalid), 32'(tbl[n].ev));
      chk({tag, "_otdata"},  n, 32'(a_otdata),  32'(tbl[n].ed));
      chk({tag, "_otlast"},  n, 32'(a_otlast),  32'(tbl[n].el));
      chk({tag, "_och"},     n, 32'(a_och),     32'(tbl[n].ech));
      chk({tag, "_itready"}, n, 32'(a_itready), 32'(tbl[n].erdy));
    end
    tbl.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_a_otvalid"}, 0, 32'(a_otvalid), 32'd0);
    chk({tag, "_a_itready"}, 0, 32'(a_itready), 32'd0);
    chk({tag, "_a_otlast"},  0, 32'(a_otlast),  32'd0);
    chk({tag, "_a_och"},     0, 32'(a_och),     32'd0);
    chk({tag, "_a_otdata"},  0, 32'(a_otdata),  32'd0);
    chk({tag, "_b_otvalid"}, 0, 32'(b_otvalid), 32'd0);
    chk({tag, "_b_itready"}, 0, 32'(b_itready), 32'd0);
  endtask

  task automatic zero_inputs();
    a_itvalid = '0; a_ihalffull = '0; a_otready = 1'b0; a_itdata = '0;
    b_itvalid = '0; b_ihalffull = '0; b_otready = 1'b0; b_itdata = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    #2;
    check_idle_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int m;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    zero_inputs();
    #3;
    check_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single source 2, ten words 0x10..0x19, MAX_BURST=4.
    for (int b = 0; b < 2; b++) begin
      add(4'b0100, 4'b0, 1'b1, 8'(8'h10 + 4*b), 0, 8'h00, 0, 4'd0, 4'b0000);
      add(4'b0100, 4'b0, 1'b1, 8'(8'h10 + 4*b), 1, 8'hA2, 0, 4'd2, 4'b0000);
      for (int w = 0; w < 4; w++) begin
        add(4'b0100, 4'b0, 1'b1, 8'(8'h10 + 4*b + w),
            1, 8'(8'h10 + 4*b + w), (w == 3), 4'd2, 4'b0100);
      end
    end
    add(4'b0100, 4'b0, 1'b1, 8'h18, 0, 8'h00, 0, 4'd0, 4'b0000);
    add(4'b0100, 4'b0, 1'b1, 8'h18, 1, 8'hA2, 0, 4'd2, 4'b0000);
    add(4'b0100, 4'b0, 1'b1, 8'h18, 1, 8'h18, 0, 4'd2, 4'b0100);
    add(4'b0100, 4'b0, 1'b1, 8'h19, 1, 8'h19, 0, 4'd2, 4'b0100);
    add(4'b0000, 4'b0, 1'b1, 8'h00, 0, 8'h00, 0, 4'd2, 4'b0100);
    add(4'b0000, 4'b0, 1'b1, 8'h00, 0, 8'h00, 0, 4'd0, 4'b0000);
    run_table("single");

    // Round-robin with all sources valid: headers A0,A1,A2,A3,A0.
    do_reset("rst_rr");
    @(posedge clk);
    #1;
    a_itvalid = 4'hF; a_ihalffull = 4'h0; a_otready = 1'b1;
    a_itdata  = lanes(8'h00);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk);
      while (!(a_otvalid && a_itready == 4'b0) && n < 12) begin
        @(negedge clk);
        n++;
      end
      chk("rr_hdr_seen", k, 32'(a_otvalid && a_itready == 4'b0), 32'd1);
      chk("rr_hdr", k, 32'(a_otdata), 32'(8'hA0 | 8'(k % 4)));
      chk("rr_och", k, 32'(a_och), 32'(k % 4));
      m = 0;
      @(negedge clk);
      while (a_itready != 4'b0 && m < 8) begin
        chk("rr_itready", k, 32'(a_itready), 32'(4'b0001 << (k % 4)));
        m++;
        @(negedge clk);
      end
      chk("rr_beats", k, 32'(m), 32'd4);
    end

    // Urgency: source 3 first despite rotation; no preemption mid-burst.
    do_reset("rst_urg");
    add(4'b1001, 4'b1000, 1'b1, 8'h30, 0, 8'h00, 0, 4'd0, 4'b0000);
    add(4'b1001, 4'b1001, 1'b1, 8'h30, 1, 8'hA3, 0, 4'd3, 4'b0000);
    for (int w = 0; w < 4; w++) begin
      add(4'b1001, 4'b1001, 1'b1, 8'(8'h30 + w),
          1, 8'(8'h70 + w), (w == 3), 4'd3, 4'b1000);
    end
    add(4'b1001, 4'b1001, 1'b1, 8'h34, 0, 8'h00, 0, 4'd0, 4'b0000);
    add(4'b1001, 4'b1001, 1'b1, 8'h34, 1, 8'hA0, 0, 4'd0, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 8'h00, 0, 8'h80, 0, 4'd0, 4'b0001);
    add(4'b0000, 4'b0000, 1'b1, 8'h00, 0, 8'h00, 0, 4'd0, 4'b0000);
    run_table("urgency");

    // Backpressure on header, a middle beat and the last beat.
    do_reset("rst_bp");
    add(4'b0010, 4'b0, 1'b1, 8'h20, 0, 8'h00, 0, 4'd0, 4'b0000);
    add(4'b0010, 4'b0, 1'b0, 8'h20, 1, 8'hA1, 0, 4'd1, 4'b0000);
    add(4'b0010, 4'b0, 1'b0, 8'h20, 1, 8'hA1, 0, 4'd1, 4'b0000);
    add(4'b0010, 4'b0, 1'b1, 8'h20, 1, 8'hA1, 0, 4'd1, 4'b0000);
    add(4'b0010, 4'b0, 1'b1, 8'h20, 1, 8'hE0, 0, 4'd1, 4'b0010);
    add(4'b0010, 4'b0, 1'b0, 8'h21, 1, 8'hE1, 0, 4'd1, 4'b0000);
    add(4'b0010, 4'b0, 1'b0, 8'h21, 1, 8'hE1, 0, 4'd1, 4'b0000);
    add(4'b0010, 4'b0, 1'b1, 8'h21, 1, 8'hE1, 0, 4'd1, 4'b0010);
    add(4'b0010, 4'b0, 1'b1, 8'h22, 1, 8'hE2, 0, 4'd1, 4'b0010);
    add(4'b0010, 4'b0, 1'b0, 8'h23, 1, 8'hE3, 1, 4'd1, 4'b0000);
    add(4'b0010, 4'b0, 1'b1, 8'h23, 1, 8'hE3, 1, 4'd1, 4'b0010);
    add(4'b0000, 4'b0, 1'b1, 8'h00, 0, 8'h00, 0, 4'd0, 4'b0000);
    run_table("bp");

    // Reset asserted during a DATA beat of source 1.
    @(posedge clk);
    #1;
    a_itvalid = 4'b0010; a_otready = 1'b1; a_itdata = lanes(8'h40);
    @(negedge clk);
    chk("mid_idle", 0, 32'(a_otvalid), 32'd0);
    @(negedge clk);
    chk("mid_hdr", 0, 32'(a_otdata), 32'hA1);
    @(negedge clk);
    chk("mid_data_valid", 0, 32'(a_otvalid), 32'd1);
    chk("mid_data", 0, 32'(a_otdata), 32'h80);
    #2;
    rst_n = 1'b0;
    a_itvalid = 4'b1111;
    #1;
    chk("mid_rst_otvalid", 0, 32'(a_otvalid), 32'd0);
    chk("mid_rst_itready", 0, 32'(a_itready), 32'd0);
    chk("mid_rst_och", 0, 32'(a_och), 32'd0);
    chk("mid_rst_otdata", 0, 32'(a_otdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hdr", 0, 32'(a_otdata), 32'hA0);
    chk("post_rst_och", 0, 32'(a_och), 32'd0);
    a_itvalid = 4'b0000;

    // HEADER_EN=0, MAX_BURST=2: data one cycle after the request.
    @(posedge clk);
    #1;
    b_itvalid = 4'b0101; b_otready = 1'b1; b_itdata = lanes(8'h55);
    @(negedge clk);
    chk("nohdr_idle", 0, 32'(b_otvalid), 32'd0);
    @(negedge clk);
    chk("nohdr_valid", 0, 32'(b_otvalid), 32'd1);
    chk("nohdr_och", 0, 32'(b_och), 32'd0);
    chk("nohdr_data", 0, 32'(b_otdata), 32'hD5);
    chk("nohdr_itready", 0, 32'(b_itready), 32'b0001);
    chk("nohdr_last0", 0, 32'(b_otlast), 32'd0);
    @(negedge clk);
    chk("nohdr_last1", 0, 32'(b_otlast), 32'd1);
    @(negedge clk);
    chk("nohdr_gap_idle", 0, 32'(b_otvalid), 32'd0);
    @(negedge clk);
    chk("nohdr_och2", 0, 32'(b_och), 32'd2);
    chk("nohdr_data2", 0, 32'(b_otdata), 32'h55);
    chk("nohdr_itready2", 0, 32'(b_itready), 32'b0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
